// File: rtl/count_run_ctrl.sv
// ---------------------------------------------------------------------------
// count_run_ctrl
//   Run controller around an internal mod-MOD counter. A start in IDLE latches
//   the wrap target and runs the counter until it has wrapped that many times,
//   then pulses done for one cycle. Abort cancels a run, and an optional hold
//   pauses counting.
//
//   Optional feature macro: COUNT_RUN_CTRL_HOLD_EN
//     defined   : hold_i pauses the run (HOLD state reachable)
//     undefined : hold_i is ignored, state_o never reads 2'b10
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   start_i        run request, sampled only in IDLE
//   abort_i        cancel an active run (RUN/HOLD)
//   hold_i         pause counting (only with COUNT_RUN_CTRL_HOLD_EN)
//   wrap_target_i  full wraps per run, latched on an accepted start
//   cnt_out_o      current counter value, 0..MOD-1
//   wrap_cnt_o     wraps completed in the current/last run
//   busy_o         high in RUN or HOLD
//   done_o         one-cycle completion pulse
//   state_o        IDLE=00 RUN=01 HOLD=10 DONE=11
// ---------------------------------------------------------------------------
module count_run_ctrl #(
    parameter int unsigned MOD    = 5,
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned WRAP_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              hold_i,
    input  logic [WRAP_W-1:0] wrap_target_i,
    output logic [CNT_W-1:0]  cnt_out_o,
    output logic [WRAP_W-1:0] wrap_cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        state_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10,
        S_DONE = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic [WRAP_W-1:0] tgt_q, tgt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hold_eff;
    logic [WRAP_W-1:0] wrap_inc;

    // Effective pause request
`ifdef COUNT_RUN_CTRL_HOLD_EN
    assign hold_eff = hold_i;
`else
    logic unused_hold;
    assign unused_hold = hold_i;
    assign hold_eff    = 1'b0;
`endif

    assign wrap_inc = wrap_q + WRAP_W'(1);

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrap_d  = wrap_q;
        tgt_d   = tgt_q;

        unique case (state_q)
            S_IDLE: begin
                // start wins over a simultaneous abort since abort is ignored here
                if (start_i) begin
                    tgt_d   = wrap_target_i;
                    cnt_d   = '0;
                    wrap_d  = '0;
                    state_d = (wrap_target_i != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    wrap_d  = '0;
                end else if (hold_eff) begin
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    wrap_d = wrap_inc;
                    if (wrap_inc == tgt_q) begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    wrap_d  = '0;
                end else if (!hold_eff) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
        done_d = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wrap_q  <= '0;
            tgt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            tgt_q   <= tgt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cnt_out_o  = cnt_q;
    assign wrap_cnt_o = wrap_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign state_o    = state_q;

endmodule
